// File: rtl/pe_link_rr_arb.sv
// Round-robin arbiter sharing one registered west-bound PE link among NUM_REQ
// valid/ready requesters; a grant lasts until in_last or MAX_BURST beats.
module pe_link_rr_arb #(
  parameter int WIDTH     = 130,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int GID_W     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ-1:0]       in_last,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic [WIDTH-1:0]         out_to_west,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [GID_W-1:0]         grant_id,
  output logic                     busy
);

  // state | meaning
  // IDLE  | no grant held; pick the next valid requester after last_grant
  // BURST | grant_id owns the link until in_last or MAX_BURST accepted beats

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state;
  logic [GID_W-1:0] last_grant;
  logic [GID_W-1:0] pick;
  logic             pick_found;
  logic [7:0]       beat_cnt;
  logic [7:0]       beat_cnt_inc;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic             sel_last;
  logic             link_free;
  logic             accept;

  // Two passes: requesters above last_grant first, then wrap to the rest.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && in_valid[i] && (GID_W'(i) > last_grant)) begin
        pick       = GID_W'(i);
        pick_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && in_valid[i] && (GID_W'(i) <= last_grant)) begin
        pick       = GID_W'(i);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GID_W'(i)) begin
        sel_data  = in_data[i*WIDTH +: WIDTH];
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
      end
    end
  end

  // The output register may take a new beat when empty or draining this cycle.
  assign link_free    = ap_start && (!out_valid || out_ready);
  assign accept       = (state == BURST) && link_free && sel_valid;
  assign beat_cnt_inc = beat_cnt + 8'd1;
  assign busy         = (state == BURST);

  always_comb begin
    in_ready = '0;
    if ((state == BURST) && link_free) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        in_ready[i] = (grant_id == GID_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_grant  <= GID_W'(NUM_REQ - 1);
      beat_cnt    <= '0;
      out_to_west <= '0;
      out_valid   <= 1'b0;
    end else begin
      if (accept) begin
        out_to_west <= sel_data;
        out_valid   <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ap_start && pick_found) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt_inc;
            if (sel_last || (beat_cnt_inc == 8'(MAX_BURST))) begin
              last_grant <= grant_id;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_link_rr_arb.sv
// Bench for pe_link_rr_arb: queue-level round-robin model plus per-cycle
// handshake rules, with directed scenarios and literal timing/order checks.
module tb_pe_link_rr_arb;

  localparam int WIDTH     = 130;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 8;
  localparam int GID_W     = 2;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     ap_start = 1'b0;
  logic                     out_ready = 1'b1;
  logic [NUM_REQ*WIDTH-1:0] in_data = '0;
  logic [NUM_REQ-1:0]       in_valid = '0;
  logic [NUM_REQ-1:0]       in_last = '0;
  logic [NUM_REQ-1:0]       in_ready;
  logic [WIDTH-1:0]         out_to_west;
  logic                     out_valid;
  logic [GID_W-1:0]         grant_id;
  logic                     busy;

  pe_link_rr_arb #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .GID_W(GID_W)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_to_west(out_to_west), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_last = NUM_REQ - 1;
  beat_t rq[NUM_REQ][$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] obs_d[$];
  int obs_cyc[$];
  logic prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input int r, input int idx);
    logic [WIDTH-1:0] v;
    v = '0;
    v[7:0] = 8'(idx);
    v[15:8] = 8'(r);
    v[64 +: 16] = 16'hA5C3;
    v[WIDTH-1 -: 8] = ~8'(idx);
    return v;
  endfunction

  task automatic push(input int r, input int idx, input logic l);
    beat_t b;
    b.d = mk(r, idx);
    b.l = l;
    rq[r].push_back(b);
  endtask

  // Serve non-empty requesters in rotation after the previous grantee; a grant
  // takes beats until the last flag or MAX_BURST beats.
  task automatic model_predict();
    beat_t cp[NUM_REQ][$];
    beat_t b;
    int g;
    int n;
    bit found;
    for (int i = 0; i < NUM_REQ; i++) cp[i] = rq[i];
    for (int iter = 0; iter < 1000; iter++) begin
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (model_last + k) % NUM_REQ;
        if (!found && cp[c].size() > 0) begin
          g = c;
          found = 1'b1;
        end
      end
      if (!found) break;
      n = 0;
      do begin
        b = cp[g].pop_front();
        exp_q.push_back(b.d);
        n++;
      end while (!b.l && n < MAX_BURST && cp[g].size() > 0);
      model_last = g;
    end
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_cyc.delete();
  endtask

  task automatic wait_obs(input int n, input int lim);
    int k;
    k = 0;
    while (obs_d.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (obs_d.size() < n) begin
      total++;
      bad++;
      $display("FAIL wait_obs: got %0d beats want %0d", obs_d.size(), n);
    end
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || busy || out_valid) && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0 || busy || out_valid) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    model_last = NUM_REQ - 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // requester drivers: present the head of each queue
  initial forever begin
    @(negedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_data[i*WIDTH +: WIDTH] = rq[i][0].d;
        in_last[i] = rq[i][0].l;
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*WIDTH +: WIDTH] = '0;
        in_last[i] = 1'b0;
      end
    end
  end

  // per-cycle compare, sampled mid-cycle before the next rising edge
  initial forever begin
    @(negedge clk);
    #2;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      chk("ready_onehot", WIDTH'($countones(in_ready) <= 1), WIDTH'(1));
      if (!busy || !ap_start || (out_valid && !out_ready))
        chk("ready_blocked", WIDTH'(in_ready), '0);
      if (in_ready != '0)
        chk("ready_owner", WIDTH'(in_ready), WIDTH'(1) << grant_id);
      if (prev_hold) begin
        chk("hold_valid", WIDTH'(out_valid), WIDTH'(1));
        chk("hold_data", out_to_west, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %h want none", out_to_west);
        end else begin
          chk("beat_data", out_to_west, exp_q.pop_front());
        end
        obs_d.push_back(out_to_west);
        obs_cyc.push_back(cyc);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (in_valid[i] && in_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      prev_hold = out_valid && !out_ready;
      prev_data = out_to_west;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int sz;
    logic [WIDTH-1:0] t;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    ap_start = 1'b1;
    #3;
    chk("rst_out_valid", WIDTH'(out_valid), '0);
    chk("rst_out_data", out_to_west, '0);
    chk("rst_busy", WIDTH'(busy), '0);
    chk("rst_grant", WIDTH'(grant_id), '0);
    chk("rst_ready", WIDTH'(in_ready), '0);

    // single requester, 3-beat burst
    @(negedge clk);
    clear_obs();
    for (int i = 0; i < 3; i++) push(0, i, i == 2);
    model_predict();
    c0 = cyc;
    drain(50);
    chk("t1_count", WIDTH'(obs_d.size()), WIDTH'(3));
    chk("t1_a", obs_d[0], mk(0, 0));
    chk("t1_c", obs_d[2], mk(0, 2));
    chk("t1_first_cyc", WIDTH'(obs_cyc[0]), WIDTH'(c0 + 2));
    chk("t1_last_cyc", WIDTH'(obs_cyc[2]), WIDTH'(c0 + 4));
    chk("t1_busy", WIDTH'(busy), '0);
    chk("t1_grant", WIDTH'(grant_id), '0);

    // round robin, one-beat bursts from all four
    apply_reset();
    @(negedge clk);
    clear_obs();
    push(0, 0, 1'b1);
    push(0, 1, 1'b1);
    for (int r = 1; r < NUM_REQ; r++) push(r, 0, 1'b1);
    model_predict();
    drain(60);
    chk("rr_count", WIDTH'(obs_d.size()), WIDTH'(5));
    for (int i = 0; i < 5; i++) begin
      t = obs_d[i];
      chk("rr_order", WIDTH'(t[15:8]), WIDTH'(rr_exp[i]));
    end
    for (int i = 0; i < 4; i++)
      chk("rr_gap", WIDTH'(obs_cyc[i+1] - obs_cyc[i]), WIDTH'(2));

    // burst cap: req1 12 beats vs req2 3 beats
    @(negedge clk);
    clear_obs();
    for (int i = 0; i < 12; i++) push(1, i, i == 11);
    for (int i = 0; i < 3; i++) push(2, i, i == 2);
    model_predict();
    drain(100);
    chk("cap_count", WIDTH'(obs_d.size()), WIDTH'(15));
    chk("cap_8th", obs_d[7], mk(1, 7));
    chk("cap_switch", obs_d[8], mk(2, 0));
    chk("cap_resume", obs_d[11], mk(1, 8));
    chk("cap_end", obs_d[14], mk(1, 11));

    // backpressure for 5 cycles mid-burst
    @(negedge clk);
    clear_obs();
    for (int i = 0; i < 6; i++) push(3, i, i == 5);
    model_predict();
    wait_obs(2, 50);
    out_ready = 1'b0;
    sz = obs_d.size();
    repeat (5) begin
      #3;
      chk("bp_valid", WIDTH'(out_valid), WIDTH'(1));
      chk("bp_ready", WIDTH'(in_ready), '0);
      chk("bp_data", out_to_west, mk(3, 2));
      @(negedge clk);
    end
    chk("bp_no_beats", WIDTH'(obs_d.size()), WIDTH'(sz));
    out_ready = 1'b1;
    drain(50);
    chk("bp_count", WIDTH'(obs_d.size()), WIDTH'(6));
    chk("bp_resume", obs_d[2], mk(3, 2));
    chk("bp_end", obs_d[5], mk(3, 5));

    // ap_start gated for 3 cycles inside a capped burst
    @(negedge clk);
    clear_obs();
    push(1, 0, 1'b0);
    push(1, 1, 1'b1);
    push(1, 2, 1'b1);
    for (int i = 0; i < 10; i++) push(2, i, i == 9);
    model_predict();
    wait_obs(5, 50);
    ap_start = 1'b0;
    sz = 0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("gate_grant", WIDTH'(grant_id), WIDTH'(2));
      chk("gate_busy", WIDTH'(busy), WIDTH'(1));
      chk("gate_ready", WIDTH'(in_ready), '0);
      if (k == 0) sz = obs_d.size();
      @(negedge clk);
    end
    chk("gate_drained", WIDTH'(out_valid), '0);
    chk("gate_no_beats", WIDTH'(obs_d.size()), WIDTH'(sz));
    ap_start = 1'b1;
    drain(100);
    chk("gate_count", WIDTH'(obs_d.size()), WIDTH'(13));
    chk("gate_cap", obs_d[9], mk(2, 7));
    chk("gate_rotate", obs_d[10], mk(1, 2));
    chk("gate_end", obs_d[12], mk(2, 9));

    // reset during req2's 4th beat
    @(negedge clk);
    clear_obs();
    for (int i = 0; i < 6; i++) push(2, i, i == 5);
    model_predict();
    wait_obs(3, 50);
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    model_last = NUM_REQ - 1;
    @(negedge clk);
    chk("mr_out_valid", WIDTH'(out_valid), '0);
    chk("mr_out_data", out_to_west, '0);
    chk("mr_busy", WIDTH'(busy), '0);
    chk("mr_grant", WIDTH'(grant_id), '0);
    reset = 1'b0;
    @(negedge clk);
    clear_obs();
    for (int r = NUM_REQ - 1; r >= 0; r--) push(r, 0, 1'b1);
    model_predict();
    drain(60);
    chk("mr_count", WIDTH'(obs_d.size()), WIDTH'(4));
    for (int i = 0; i < 4; i++) begin
      t = obs_d[i];
      chk("mr_order", WIDTH'(t[15:8]), WIDTH'(rr_exp[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
